// File: rtl/racer_pkg.sv
// Shared types and colour constants for the racer track renderer.
package racer_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 32;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   vis;
    } sprite_pos_t;

    localparam color_t GRASS_COLOR = 32'h0056B000;
    localparam color_t ROAD_COLOR  = 32'h00000000;
    localparam color_t TRANSP_KEY  = 32'h00FF00FF;

endpackage

// File: rtl/sprite_hit.sv
// One sprite channel: registered rectangle hit test plus the texel address sent to the sprite ROM.
module sprite_hit
    import racer_pkg::*;
#(
    parameter int SPR_W = 100,
    parameter int SPR_H = 124
) (
    input  logic        clk,
    input  logic        rst,
    input  sprite_pos_t spritePos,
    input  coord_t      pixelX,
    input  coord_t      pixelY,
    output logic        hit,
    output coord_t      posX,
    output coord_t      posY
);

    typedef logic [COORD_W:0] wide_t;

    // One extra bit keeps x+SPR_W from wrapping, so a sprite near the right edge clips instead.
    wide_t pxWide, pyWide, xWide, yWide, xEnd, yEnd;
    logic  inX, inY;

    assign pxWide = {1'b0, pixelX};
    assign pyWide = {1'b0, pixelY};
    assign xWide  = {1'b0, spritePos.x};
    assign yWide  = {1'b0, spritePos.y};
    assign xEnd   = xWide + wide_t'(SPR_W);
    assign yEnd   = yWide + wide_t'(SPR_H);
    assign inX    = (pxWide >= xWide) && (pxWide < xEnd);
    assign inY    = (pyWide >= yWide) && (pyWide < yEnd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit  <= 1'b0;
            posX <= '0;
            posY <= '0;
        end else begin
            hit  <= spritePos.vis & inX & inY;
            posX <= pixelX - spritePos.x;
            posY <= pixelY - spritePos.y;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES ROM-backed sprites over the track background; positions are
// double-buffered so the active bank only changes at frame start.
module sprite_compositor
    import racer_pkg::*;
#(
    parameter int                        NUM_SPRITES = 4,
    parameter int                        COORD_W     = racer_pkg::COORD_W,
    parameter int                        COLOR_W     = racer_pkg::COLOR_W,
    parameter int                        SPR_W       = 100,
    parameter int                        SPR_H       = 124,
    parameter int                        MARGIN_L    = 100,
    parameter int                        MARGIN_R    = 540,
    parameter logic [COLOR_W-1:0]        GRASS_COLOR = racer_pkg::GRASS_COLOR,
    parameter logic [COLOR_W-1:0]        ROAD_COLOR  = racer_pkg::ROAD_COLOR,
    parameter logic [COLOR_W-1:0]        TRANSP_KEY  = racer_pkg::TRANSP_KEY,
    parameter int                        ROM_LAT     = 1,
    localparam int                       IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             pixelX,
    input  logic [COORD_W-1:0]             pixelY,
    input  logic                           frame_start,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [COORD_W-1:0]             wr_x,
    input  logic [COORD_W-1:0]             wr_y,
    input  logic                           wr_vis,
    output logic                           wr_ready,
    output logic [NUM_SPRITES*COORD_W-1:0] spr_posX,
    output logic [NUM_SPRITES*COORD_W-1:0] spr_posY,
    input  logic [NUM_SPRITES*COLOR_W-1:0] spr_dato,
    output logic [COLOR_W-1:0]             dato
);

    localparam logic [31:0] MARGIN_L_W = MARGIN_L;
    localparam logic [31:0] MARGIN_R_W = MARGIN_R;
    localparam logic [COORD_W-1:0] MARGIN_L_C = MARGIN_L_W[COORD_W-1:0];
    localparam logic [COORD_W-1:0] MARGIN_R_C = MARGIN_R_W[COORD_W-1:0];

    sprite_pos_t shadowBank [NUM_SPRITES];
    sprite_pos_t activeBank [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] hitNow;
    logic [COLOR_W-1:0]     bgNow;
    logic [NUM_SPRITES-1:0] hitPipe [ROM_LAT];
    logic [COLOR_W-1:0]     bgPipe  [ROM_LAT];
    logic [COLOR_W-1:0]     pixelSel;

    // Writes land in the shadow bank; the frame_start cycle refuses them so commit sees a stable bank.
    assign wr_ready = ~frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadowBank[i] <= '0;
                activeBank[i] <= '0;
            end
        end else begin
            if (wr_en && wr_ready && (int'(wr_idx) < NUM_SPRITES))
                shadowBank[wr_idx] <= '{x: wr_x, y: wr_y, vis: wr_vis};
            if (frame_start)
                for (int i = 0; i < NUM_SPRITES; i++)
                    activeBank[i] <= shadowBank[i];
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : gen_channel
        sprite_hit #(
            .SPR_W(SPR_W),
            .SPR_H(SPR_H)
        ) u_hit (
            .clk      (clk),
            .rst      (rst),
            .spritePos(activeBank[g]),
            .pixelX   (pixelX),
            .pixelY   (pixelY),
            .hit      (hitNow[g]),
            .posX     (spr_posX[g*COORD_W +: COORD_W]),
            .posY     (spr_posY[g*COORD_W +: COORD_W])
        );
    end

    // Background is resolved in stage 0 and then rides the delay line alongside the hit vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bgNow <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                hitPipe[k] <= '0;
                bgPipe[k]  <= '0;
            end
        end else begin
            bgNow      <= ((pixelX < MARGIN_L_C) || (pixelX > MARGIN_R_C)) ? GRASS_COLOR : ROAD_COLOR;
            hitPipe[0] <= hitNow;
            bgPipe[0]  <= bgNow;
            for (int k = 1; k < ROM_LAT; k++) begin
                hitPipe[k] <= hitPipe[k-1];
                bgPipe[k]  <= bgPipe[k-1];
            end
        end
    end

    // Scanning from the last channel down lets the lowest opaque index win.
    always_comb begin
        pixelSel = bgPipe[ROM_LAT-1];
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hitPipe[ROM_LAT-1][i] && (spr_dato[i*COLOR_W +: COLOR_W] != TRANSP_KEY))
                pixelSel = spr_dato[i*COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dato <= '0;
        else     dato <= pixelSel;
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with a 1-cycle sprite ROM model.
module tb_sprite_compositor;
    import racer_pkg::*;

    localparam int NUM = 4;
    localparam int LAT = 1;
    localparam logic [31:0] GRASS = 32'h0056B000;
    localparam logic [31:0] ROAD  = 32'h00000000;
    localparam logic [31:0] KEY   = 32'h00FF00FF;
    localparam logic [31:0] JUNK  = 32'hDEADBEEF;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] expDato;
        string       name;
    } vec_t;

    logic            clk, rst;
    logic [9:0]      pixelX, pixelY;
    logic            frame_start, wr_en, wr_vis, wr_ready;
    logic [1:0]      wr_idx;
    logic [9:0]      wr_x, wr_y;
    logic [NUM*10-1:0] spr_posX, spr_posY;
    logic [NUM*32-1:0] spr_dato;
    logic [31:0]     dato;

    logic [31:0] romColor [NUM];
    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    sprite_compositor #(
        .NUM_SPRITES(NUM),
        .ROM_LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .frame_start(frame_start),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_vis     (wr_vis),
        .wr_ready   (wr_ready),
        .spr_posX   (spr_posX),
        .spr_posY   (spr_posY),
        .spr_dato   (spr_dato),
        .dato       (dato)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM: returns the channel colour for in-range texels, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < NUM; i++)
            spr_dato[i*32 +: 32] <= ((spr_posX[i*10 +: 10] < 10'd100) && (spr_posY[i*10 +: 10] < 10'd124))
                                    ? romColor[i] : JUNK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Presents one pixel between idle (0,0) pixels and checks the exact output cycle.
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [31:0] expected, input string name);
        pixelX = x;
        pixelY = y;
        @(negedge clk);
        pixelX = 10'd0;
        pixelY = 10'd0;
        repeat (LAT) @(negedge clk);
        checkOutput({name, " early"}, dato, GRASS);
        @(negedge clk);
        checkOutput(name, dato, expected);
    endtask

    task automatic writeSprite(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y, input logic vis);
        wr_en  = 1'b1;
        wr_idx = idx;
        wr_x   = x;
        wr_y   = y;
        wr_vis = vis;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic frameStartPulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pixelX = '0; pixelY = '0;
        frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
        wr_x = '0; wr_y = '0; wr_vis = 1'b0;
        romColor[0] = 32'h0000FF00;
        romColor[1] = 32'h000000FF;
        romColor[2] = 32'h00ABCDEF;
        romColor[3] = 32'h00111111;

        vecs.push_back('{10'd350,  10'd350, 32'h0000FF00, "priority s0 over s1"});
        vecs.push_back('{10'd399,  10'd350, 32'h0000FF00, "right edge inside"});
        vecs.push_back('{10'd400,  10'd350, ROAD,         "right edge outside"});
        vecs.push_back('{10'd299,  10'd350, ROAD,         "left edge outside"});
        vecs.push_back('{10'd350,  10'd423, 32'h0000FF00, "bottom edge inside"});
        vecs.push_back('{10'd350,  10'd424, ROAD,         "bottom edge outside"});
        vecs.push_back('{10'd50,   10'd10,  GRASS,        "x1000 no wrap"});
        vecs.push_back('{10'd1010, 10'd10,  32'h00ABCDEF, "x1000 clipped hit"});
        vecs.push_back('{10'd650,  10'd150, GRASS,        "invisible sprite"});
        vecs.push_back('{10'd99,   10'd200, GRASS,        "margin 99"});
        vecs.push_back('{10'd100,  10'd200, ROAD,         "margin 100"});
        vecs.push_back('{10'd540,  10'd200, ROAD,         "margin 540"});
        vecs.push_back('{10'd541,  10'd200, GRASS,        "margin 541"});

        repeat (3) @(negedge clk);
        checkOutput("reset dato", dato, ROAD);
        checkOutput("reset wr_ready", {31'd0, wr_ready}, 32'd1);
        rst = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Shadow write without a commit must stay invisible.
        writeSprite(2'd0, 10'd300, 10'd300, 1'b1);
        applyStimulus(10'd350, 10'd350, ROAD, "no commit");

        frameStartPulse();
        pixelX = 10'd350;
        pixelY = 10'd350;
        @(negedge clk);
        checkOutput("spr_posX0", {22'd0, spr_posX[9:0]}, 32'd50);
        checkOutput("spr_posY0", {22'd0, spr_posY[9:0]}, 32'd50);
        pixelX = 10'd0;
        pixelY = 10'd0;
        repeat (LAT + 2) @(negedge clk);
        applyStimulus(10'd350, 10'd350, 32'h0000FF00, "committed hit");

        // Reset in the middle of a frame.
        pixelX = 10'd50;
        pixelY = 10'd350;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midframe rst dato", dato, ROAD);
        checkOutput("midframe rst wr_ready", {31'd0, wr_ready}, 32'd1);
        checkOutput("midframe rst posX", {22'd0, spr_posX[9:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        checkOutput("post rst flushed", dato, ROAD);
        @(negedge clk);
        checkOutput("post rst background", dato, GRASS);
        pixelX = 10'd0;
        pixelY = 10'd0;
        repeat (LAT + 2) @(negedge clk);
        applyStimulus(10'd350, 10'd350, ROAD, "bank cleared by rst");

        // Last write lands the cycle right before frame_start and must be committed.
        writeSprite(2'd3, 10'd600, 10'd100, 1'b0);
        writeSprite(2'd0, 10'd300, 10'd300, 1'b1);
        writeSprite(2'd1, 10'd300, 10'd300, 1'b1);
        writeSprite(2'd2, 10'd1000, 10'd0, 1'b1);
        frameStartPulse();

        foreach (vecs[i])
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].expDato, vecs[i].name);

        // Write colliding with frame_start is refused.
        wr_en = 1'b1; wr_idx = 2'd0; wr_x = 10'd700; wr_y = 10'd700; wr_vis = 1'b1;
        frame_start = 1'b1;
        #1;
        checkOutput("wr_ready at frame_start", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        frame_start = 1'b0;
        frameStartPulse();
        applyStimulus(10'd350, 10'd350, 32'h0000FF00, "dropped write");

        romColor[0] = KEY;
        applyStimulus(10'd350, 10'd350, 32'h000000FF, "transparent s0");
        romColor[0] = 32'h00123456;
        applyStimulus(10'd350, 10'd350, 32'h00123456, "opaque s0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
